neg_accumulator: RTL and testbench

//   Sequential stage directly downstream of the 4-bit two's-complement negate unit.
//   - Each burst accepts NUM_OPS signed operands (the negated values) over a valid/ready handshake.
//   - Sums them into a WIDTH-bit signed accumulator and flags signed overflow.
//   - Presents the final sum on a valid/ready output to the display/ALU result path.

---
 rtl/neg_accumulator_if.sv | 32 +++
 rtl/neg_accumulator.sv | 109 ++++++++++
 tb/tb_neg_accumulator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/neg_accumulator_if.sv
//==============================================================================
// neg_accumulator_if : operand input, result output and status signals of
//                      neg_accumulator, grouped with master/slave views.
// Rev 1.0
//==============================================================================
`default_nettype none

interface neg_accumulator_if #(
  parameter int WIDTH = 4
);
  logic                    start;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] sum;
  logic                    sum_valid;
  logic                    out_ready;
  logic                    overflow;
  logic                    busy;

  modport master (
    output start, in_data, in_valid, out_ready,
    input  in_ready, sum, sum_valid, overflow, busy
  );

  modport slave (
    input  start, in_data, in_valid, out_ready,
    output in_ready, sum, sum_valid, overflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/neg_accumulator.sv
//==============================================================================
// neg_accumulator : sums a burst of NUM_OPS signed operands with sticky signed
//                   overflow and presents the result over valid/ready.
// Rev 1.0
//==============================================================================
`default_nettype none

module neg_accumulator #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  neg_accumulator_if.slave   bus
);

  localparam int                CNT_W    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic                    overflow;
  logic                    in_ready;
  logic                    sum_valid;
  logic                    busy;

  logic signed [WIDTH-1:0] add_res;
  logic                    add_ovf;

  // Overflow only possible when both addends share a sign and the result flips it.
  always_comb begin
    add_res = acc + bus.in_data;
    add_ovf = (bus.in_data[WIDTH-1] == acc[WIDTH-1]) &&
              (add_res[WIDTH-1] != acc[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      in_ready  <= 1'b0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ACCUM: begin
          if (bus.in_valid && in_ready) begin
            acc <= add_res;
            if (add_ovf) begin
              overflow <= 1'b1;
            end
            if (count == LAST_CNT) begin
              state     <= DONE;
              count     <= '0;
              in_ready  <= 1'b0;
              sum_valid <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          sum_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sum       = acc;
  assign bus.overflow  = overflow;
  assign bus.in_ready  = in_ready;
  assign bus.sum_valid = sum_valid;
  assign bus.busy      = busy;

endmodule

`default_nettype wire

// File: tb/tb_neg_accumulator.sv
//==============================================================================
// tb_neg_accumulator : directed and randomized bursts checked against an
//                      integer-arithmetic model of the accumulator.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_neg_accumulator;

  localparam int WIDTH   = 4;
  localparam int NUM_OPS = 4;
  localparam int HALF    = 1 << (WIDTH - 1);
  localparam int MODV    = 1 << WIDTH;

  typedef int ops_t [NUM_OPS];

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  neg_accumulator_if #(.WIDTH(WIDTH)) bus ();

  neg_accumulator #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Two's-complement wrap of an exact integer into WIDTH bits.
  function automatic int wrap(input int x);
    return ((x + HALF) & (MODV - 1)) - HALF;
  endfunction

  // One full burst; inputs driven and outputs sampled on the falling edge.
  task automatic run_burst(input ops_t ops, input logic [15:0] vpat,
                           input bit use_pat, input bit poke_start, input int hold);
    int  acc  = 0;
    bit  ovf  = 1'b0;
    int  idx  = 0;
    int  step = 0;
    int  exact;
    bit  vld;

    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_sum_valid", bus.sum_valid, 0);
    bus.start     = 1'b1;
    bus.in_valid  = 1'b1;               // must not be accepted while IDLE
    bus.in_data   = WIDTH'($urandom);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", bus.busy, 1);
    check("start_clears_overflow", bus.overflow, 0);
    check("start_clears_sum", bus.sum, 0);

    while (idx < NUM_OPS && step < 200) begin
      check("accum_in_ready", bus.in_ready, 1);
      check("accum_sum_valid", bus.sum_valid, 0);
      check("partial_sum", bus.sum, acc);
      check("partial_overflow", bus.overflow, int'(ovf));
      vld          = use_pat ? vpat[step % 16] : 1'($urandom_range(0, 1));
      bus.in_valid = vld;
      bus.in_data  = vld ? WIDTH'(ops[idx]) : WIDTH'($urandom);
      bus.start    = poke_start & 1'($urandom_range(0, 1));
      @(negedge clk);
      if (vld) begin
        exact = acc + ops[idx];
        if (exact > HALF - 1 || exact < -HALF) ovf = 1'b1;
        acc = wrap(exact);
        idx++;
      end
      step++;
    end
    if (idx < NUM_OPS) check("accept_timeout", idx, NUM_OPS);
    bus.in_valid = 1'b0;

    for (int h = 0; h <= hold; h++) begin
      check("done_sum_valid", bus.sum_valid, 1);
      check("done_in_ready", bus.in_ready, 0);
      check("done_busy", bus.busy, 1);
      check("done_sum", bus.sum, acc);
      check("done_overflow", bus.overflow, int'(ovf));
      if (h < hold) begin
        bus.start = poke_start;
        @(negedge clk);
      end
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_sum_valid", bus.sum_valid, 0);
    check("release_busy", bus.busy, 0);
    check("held_sum", bus.sum, acc);
    check("held_overflow", bus.overflow, int'(ovf));
  endtask

  task automatic reset_mid_burst();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'sd3;
    @(negedge clk);
    bus.in_data = 4'sd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_reset_sum", bus.sum, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sum", bus.sum, 0);
    check("async_rst_overflow", bus.overflow, 0);
    check("async_rst_in_ready", bus.in_ready, 0);
    check("async_rst_sum_valid", bus.sum_valid, 0);
    check("async_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_sum_valid", bus.sum_valid, 0);
      check("post_rst_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    ops_t o;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sum", bus.sum, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_sum_valid", bus.sum_valid, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    o = '{1, 2, -1, 3};  run_burst(o, 16'hFFFF, 1'b1, 1'b0, 0);
    o = '{7, 1, 0, 0};   run_burst(o, 16'hFFFF, 1'b1, 1'b0, 0);
    o = '{7, 1, -1, 0};  run_burst(o, 16'hFFFF, 1'b1, 1'b0, 1);
    o = '{2, -3, 4, 1};  run_burst(o, 16'b0000_0000_0101_1001, 1'b1, 1'b0, 5);
    o = '{3, -2, 1, -4}; run_burst(o, 16'hFFFF, 1'b1, 1'b1, 3);
    o = '{-8, -1, 0, 0}; run_burst(o, 16'hFFFF, 1'b1, 1'b0, 0);
    o = '{1, 1, 1, 1};   run_burst(o, 16'hFFFF, 1'b1, 1'b0, 0);

    reset_mid_burst();

    for (int b = 0; b < 30; b++) begin
      for (int k = 0; k < NUM_OPS; k++) o[k] = int'($urandom_range(0, MODV - 1)) - HALF;
      run_burst(o, 16'hFFFF, 1'b0, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
